// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the J-type target helper.
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // The upper nibble comes from the jump's own PC+4, not the fetch PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: branch beats jump beats stall beats sequential advance.
module pc_next_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] if_pc4_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        stall_i,
  output logic [31:0] pc_next_o,
  output logic        redirect_o
);

  always_comb begin
    pc_next_o  = pc_i + 32'd4;
    redirect_o = branch_taken_i | jump_i;
    if (branch_taken_i) begin
      pc_next_o = {branch_target_i[31:2], 2'b00};
    end else if (jump_i) begin
      pc_next_o = jump_target(if_pc4_i, jump_index_i);
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the memory address and
// captures the returned word into the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic [31:0]  instruc,
  output logic [31:0]  address,
  output logic [31:0]  if_instruc,
  output logic [31:0]  if_pc4,
  output logic         if_valid,
  output logic         addr_err,
  output logic [31:0]  fetch_count
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] if_instruc_q, if_instruc_d;
  logic [31:0]        if_pc4_q, if_pc4_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic [31:0]        pc_next;
  logic               redirect;
  logic [31:0]        pc_plus4;

  pc_next_logic u_pc_next (
    .pc_i            (pc_q),
    .if_pc4_i        (if_pc4_q),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .stall_i         (stall),
    .pc_next_o       (pc_next),
    .redirect_o      (redirect)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign addr_err = ({1'b0, pc_q} >= IMEM_BYTES) | (pc_q[1:0] != 2'b00);

  // A redirect squashes the wrong-path word even while the hazard unit stalls.
  always_comb begin
    pc_d          = pc_next;
    if_instruc_d  = if_instruc_q;
    if_pc4_d      = if_pc4_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect || flush) begin
      if_instruc_d = NOP_INSTR;
      if_pc4_d     = pc_plus4;
      if_valid_d   = 1'b0;
    end else if (!stall) begin
      if_pc4_d = pc_plus4;
      if (addr_err) begin
        if_instruc_d = NOP_INSTR;
        if_valid_d   = 1'b0;
      end else begin
        if_instruc_d  = instruc;
        if_valid_d    = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_instruc_q  <= NOP_INSTR;
      if_pc4_q      <= 32'h0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      if_instruc_q  <= if_instruc_d;
      if_pc4_q      <= if_pc4_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign address     = pc_q;
  assign if_instruc  = if_instruc_q;
  assign if_pc4      = if_pc4_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory stub, reference model and literal checks.
module tb_fetch_unit;

  localparam int          IMEM_WORDS = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] instruc = 32'h0;
  logic [31:0] address, if_instruc, if_pc4, fetch_count;
  logic        if_valid, addr_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [IMEM_WORDS];

  // Reference model state.
  bit          m_init = 1'b0;
  logic [31:0] m_pc, m_ins, m_pc4, m_cnt;
  logic        m_val;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .instruc       (instruc),
    .address       (address),
    .if_instruc    (if_instruc),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .addr_err      (addr_err),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ($isunknown(a) || a >= IMEM_WORDS * 4 || a[1:0] != 2'b00) return 32'hBAD0_BAD0;
    return mem[a[6:2]];
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    return (a >= IMEM_WORDS * 4) || (a % 4 != 0);
  endfunction

  // Instruction memory answers on negedge for the current address.
  always @(negedge clock) instruc <= mem_word(address);

  // Behavioural model of the stage, stepped on each rising edge.
  always @(posedge clock) begin
    logic [31:0] old_pc, old_pc4;
    old_pc  = m_pc;
    old_pc4 = m_pc4;
    if (reset) begin
      m_pc = RESET_PC; m_ins = 0; m_pc4 = 0; m_val = 0; m_cnt = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      if (branch_taken || jump || flush) begin
        m_ins = 0; m_val = 0; m_pc4 = old_pc + 4;
      end else if (!stall) begin
        m_pc4 = old_pc + 4;
        if (model_err(old_pc)) begin
          m_ins = 0; m_val = 0;
        end else begin
          m_ins = mem_word(old_pc); m_val = 1; m_cnt = m_cnt + 1;
        end
      end
      if (branch_taken)  m_pc = branch_target & ~32'd3;
      else if (jump)     m_pc = {old_pc4[31:28], jump_index, 2'b00};
      else if (!stall)   m_pc = old_pc + 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clock) begin
    #1;
    if (m_init) begin
      chk("model.address", address, m_pc);
      chk("model.if_instruc", if_instruc, m_ins);
      chk("model.if_pc4", if_pc4, m_pc4);
      chk("model.if_valid", {31'b0, if_valid}, {31'b0, m_val});
      chk("model.fetch_count", fetch_count, m_cnt);
      chk("model.addr_err", {31'b0, addr_err}, {31'b0, model_err(m_pc)});
    end
  end

  task automatic step(input string label);
    @(posedge clock);
    #2;
    $display("t=%0t %-12s addr=%08h ins=%08h pc4=%08h v=%0d err=%0d cnt=%0d",
             $time, label, address, if_instruc, if_pc4, if_valid, addr_err, fetch_count);
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h1111_1111 * 32'(i + 1);
    idle();
    reset = 1;
    step("reset");
    step("reset");
    chk("rst.address", address, RESET_PC);
    chk("rst.if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst.fetch_count", fetch_count, 32'h0);
    reset = 0;

    step("seq0");
    chk("seq0.address", address, 32'h4);
    chk("seq0.if_instruc", if_instruc, 32'h1111_1111);
    chk("seq0.if_pc4", if_pc4, 32'h4);
    chk("seq0.if_valid", {31'b0, if_valid}, 32'h1);
    step("seq1");
    chk("seq1.address", address, 32'h8);
    chk("seq1.if_instruc", if_instruc, 32'h2222_2222);

    stall = 1;
    step("stall");
    step("stall");
    chk("stall.address", address, 32'h8);
    chk("stall.if_instruc", if_instruc, 32'h2222_2222);
    chk("stall.fetch_count", fetch_count, 32'h2);
    stall = 0;
    step("resume");
    chk("resume.address", address, 32'hC);
    chk("resume.if_instruc", if_instruc, 32'h3333_3333);

    branch_taken = 1; branch_target = 32'h0000_0042; stall = 1;
    step("branch+stall");
    chk("br.address", address, 32'h40);
    chk("br.if_valid", {31'b0, if_valid}, 32'h0);
    idle();
    step("br.capture");
    chk("br.capture.ins", if_instruc, 32'h2222_2221);
    chk("br.capture.pc4", if_pc4, 32'h44);

    branch_taken = 1; branch_target = 32'h0000_000C;
    step("branch");
    idle();
    step("seq3");
    chk("pre.jump.if_pc4", if_pc4, 32'h10);
    jump = 1; jump_index = 26'h5;
    step("jump");
    chk("jump.address", address, 32'h14);
    chk("jump.if_instruc", if_instruc, 32'h0);
    idle();
    step("jump.capture");
    chk("jump.capture.ins", if_instruc, 32'h6666_6666);

    flush = 1;
    step("flush");
    chk("flush.address", address, 32'h1C);
    chk("flush.if_valid", {31'b0, if_valid}, 32'h0);
    idle();

    branch_taken = 1; branch_target = 32'h0000_007C;
    step("branch.end");
    idle();
    step("last");
    chk("last.address", address, 32'h80);
    chk("last.addr_err", {31'b0, addr_err}, 32'h1);
    chk("last.fetch_count", fetch_count, 32'h7);
    step("oor");
    chk("oor.address", address, 32'h84);
    chk("oor.if_valid", {31'b0, if_valid}, 32'h0);
    chk("oor.fetch_count", fetch_count, 32'h7);

    reset = 1; branch_taken = 1; branch_target = 32'h0000_0020;
    step("reset+branch");
    chk("rstbr.address", address, RESET_PC);
    chk("rstbr.if_instruc", if_instruc, 32'h0);
    chk("rstbr.if_pc4", if_pc4, 32'h0);
    chk("rstbr.fetch_count", fetch_count, 32'h0);
    reset = 0; idle();
    step("seq0b");
    step("seq1b");
    chk("after.if_instruc", if_instruc, 32'h2222_2222);

    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
